vending_fsm_param: RTL and testbench
====================================

Name: vending_fsm_param

Overview:
- Parametrised successor to the single-config vending controller.
- Item count, coin count, total width and timeout depth are parameters; prices and coin values are runtime vectors.
- Registered balance and a 3-state FSM (IDLE/WAIT/RETURN).
- Multi-cycle greedy change return, one coin per cycle; coin-overflow rejection.
- Sits between the coin acceptor/keypad front end and the dispenser/change hopper.

Parameters:
- NUM_ITEMS, 4, number of items.
- NUM_COINS, 3, number of coin denominations; coin index ascending by value.
- TOTAL_BITS, 16, width of balance and all money arithmetic.
- WAIT_CYCLES, 100, idle cycles before automatic return; 1..2^16-1.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on rising clk.
- i_input_coin  in  NUM_COINS  per-denomination strobe; several may assert in one cycle.
- i_select_item  in  NUM_ITEMS  selection strobe.
- i_trigger_return  in  1  request change return.
- i_item_price  in  NUM_ITEMS*TOTAL_BITS  flattened prices, item k at [k*TOTAL_BITS +: TOTAL_BITS].
- i_coin_value  in  NUM_COINS*TOTAL_BITS  flattened values, strictly ascending with index; value 0 not allowed.
- i_restock_item  in  NUM_ITEMS  stock reload strobe; used only with VM_ITEM_STOCK_EN.
- o_available_item  out  NUM_ITEMS  combinational: state!=RETURN && balance>=price[k] (&& stock[k]!=0 with feature).
- o_output_item  out  NUM_ITEMS  registered one-hot vend pulse, 1 cycle.
- o_return_coin  out  NUM_COINS  registered one-hot change pulse, 1 cycle per coin.
- o_coin_reject  out  1  registered pulse: coin(s) this cycle not credited.
- o_balance  out  TOTAL_BITS  registered current balance.
- o_busy  out  1  1 while in RETURN.

Behaviour:
- Reset (reset_n=0 at clk edge): state=IDLE, balance=0, timer=WAIT_CYCLES, all pulse outputs 0, o_busy=0. Reset mid-RETURN abandons return; remaining balance is discarded.
- coin_sum = sum of i_coin_value[j] over asserted i_input_coin[j], computed at TOTAL_BITS+1 bits.
- Coin acceptance: allowed in IDLE/WAIT only.
  - If balance+coin_sum exceeds 2^TOTAL_BITS-1, all coins that cycle are rejected and o_coin_reject=1 next cycle.
  - Coins in RETURN are also rejected.
- Vend: in IDLE/WAIT, the lowest-index k with i_select_item[k] && o_available_item[k] vends; other selections are ignored that cycle.
  - Availability uses the pre-edge balance.
  - Next balance = balance + accepted coin_sum - price[k].
  - o_output_item[k]=1 for one cycle.
  - A selection of an unavailable item has no effect.
- Timer:
  - Reloads to WAIT_CYCLES on any accepted coin or vend; otherwise decrements in WAIT.
  - Held at WAIT_CYCLES in IDLE and RETURN.
- Transitions:
  - IDLE -> WAIT when a coin is accepted.
  - WAIT -> RETURN when balance != 0 and either i_trigger_return=1, or timer reaches 0 with no coin/vend that cycle.
  - WAIT -> IDLE when balance becomes 0: after a vend, on trigger, or on timeout.
  - Trigger in IDLE is ignored.
  - Coin and trigger in the same cycle in WAIT: the coin is credited first, then RETURN is entered.
  - RETURN, each cycle: choose the highest j with coin_value[j] <= balance; pulse o_return_coin[j]; subtract coin_value[j].
  - If balance != 0 but less than the smallest coin, the residue is forfeited: balance=0, no pulse.
  - RETURN -> IDLE on the cycle after balance becomes 0.
  - i_trigger_return and i_select_item are ignored in RETURN.
- Arithmetic: all compares are unsigned at TOTAL_BITS; balance never wraps.

Optional Feature:
- Macro: VM_ITEM_STOCK_EN.
- Enabled:
  - Per-item 4-bit stock counter, reset to 4'd15.
  - A vend decrements stock[k]; i_restock_item[k] reloads it to 15.
  - If restock and vend of the same item coincide, restock wins.
  - An item with stock 0 is unavailable.
- Disabled: no counters; stock treated as infinite; i_restock_item ignored.

Test Plan:
Common setup: coins {100,500,1000}, prices {400,500,1000,2000}, TOTAL_BITS=16, WAIT_CYCLES=10.
- Reset: hold reset_n=0 for 2 clocks with coins asserted -> o_balance=0, all pulses 0, o_busy=0 after release.
- Coins and vend: insert 500 then 1000 -> o_balance=1500 and avail=0111. Select item1 -> o_output_item=0010 for 1 cycle, o_balance=1000. Select items 0 and 2 together -> only item0 vends, balance=600.
- Change return: balance=1600, trigger -> o_return_coin=100, then 010, then 001 on consecutive cycles; o_busy high 3 cycles; then IDLE with o_balance=0.
- Timeout: balance=500 and 10 idle cycles -> RETURN, o_return_coin=010. A coin inserted at timer=3 instead reloads the timer and no return occurs.
- Overflow and RETURN rejection: balance=65000, insert 1000 -> o_coin_reject=1, balance unchanged. Coin during RETURN -> rejected.
- Stock (VM_ITEM_STOCK_EN): vend item0 15 times -> avail[0]=0 despite sufficient balance. Assert i_restock_item[0] -> avail[0]=1 next cycle.

Source files
------------

// File: rtl/vending_fsm_param.sv
// vending_fsm_param: parametrised vending controller.
// A registered balance and an IDLE/WAIT/RETURN state machine sit between the
// coin acceptor/keypad front end and the dispenser/change hopper. Change is
// paid out greedily, one coin per cycle.
// Optional feature macro VM_ITEM_STOCK_EN adds a 4-bit stock counter per item.
module vending_fsm_param #(
  parameter int NUM_ITEMS   = 4,
  parameter int NUM_COINS   = 3,
  parameter int TOTAL_BITS  = 16,
  parameter int WAIT_CYCLES = 100
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_COINS-1:0]            i_input_coin,
  input  logic [NUM_ITEMS-1:0]            i_select_item,
  input  logic                            i_trigger_return,
  input  logic [NUM_ITEMS*TOTAL_BITS-1:0] i_item_price,
  input  logic [NUM_COINS*TOTAL_BITS-1:0] i_coin_value,
  input  logic [NUM_ITEMS-1:0]            i_restock_item,
  output logic [NUM_ITEMS-1:0]            o_available_item,
  output logic [NUM_ITEMS-1:0]            o_output_item,
  output logic [NUM_COINS-1:0]            o_return_coin,
  output logic                            o_coin_reject,
  output logic [TOTAL_BITS-1:0]           o_balance,
  output logic                            o_busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RETURN} state_t;

  localparam logic [15:0] WAIT_INIT = 16'(WAIT_CYCLES);
  localparam logic [TOTAL_BITS+1:0] MAX_BAL = {2'b00, {TOTAL_BITS{1'b1}}};

  state_t                  state_reg, state_next;
  logic [TOTAL_BITS-1:0]   balance_reg, balance_next;
  logic [15:0]             timer_reg, timer_next;
  logic [NUM_ITEMS-1:0]    item_reg, item_next;
  logic [NUM_COINS-1:0]    ret_reg, ret_next;
  logic                    reject_reg, reject_next;

  logic [TOTAL_BITS:0]     coin_sum;
  logic [TOTAL_BITS+1:0]   total;
  logic                    coin_any, overflow, coin_ok;
  logic [TOTAL_BITS-1:0]   credit, bal_after;
  logic                    vend_hit;
  logic [NUM_ITEMS-1:0]    vend_onehot;
  logic [TOTAL_BITS-1:0]   vend_price;
  logic                    ret_hit;
  logic [NUM_COINS-1:0]    ret_onehot;
  logic [TOTAL_BITS-1:0]   ret_value;
  logic [NUM_ITEMS-1:0]    has_stock;

`ifdef VM_ITEM_STOCK_EN
  logic [3:0] stock_reg [NUM_ITEMS];

  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_stock
      // Per-item stock: restock beats a coincident vend.
      always_ff @(posedge clk) begin
        if (!reset_n)
          stock_reg[gi] <= 4'd15;
        else if (i_restock_item[gi])
          stock_reg[gi] <= 4'd15;
        else if (item_next[gi])
          stock_reg[gi] <= stock_reg[gi] - 4'd1;
      end
      assign has_stock[gi] = (stock_reg[gi] != 4'd0);
    end
  endgenerate
`else
  logic unused_restock;
  assign unused_restock = ^i_restock_item;
  assign has_stock      = '1;
`endif

  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_avail
      assign o_available_item[gi] = (state_reg != ST_RETURN) &&
                                    (balance_reg >= i_item_price[gi*TOTAL_BITS +: TOTAL_BITS]) &&
                                    has_stock[gi];
    end
  endgenerate

  // Coin sum, overflow check, vend choice (lowest index) and greedy change coin.
  always_comb begin
    coin_sum    = '0;
    vend_hit    = 1'b0;
    vend_onehot = '0;
    vend_price  = '0;
    ret_hit     = 1'b0;
    ret_onehot  = '0;
    ret_value   = '0;
    for (int j = 0; j < NUM_COINS; j++) begin
      if (i_input_coin[j])
        coin_sum = coin_sum + {1'b0, i_coin_value[j*TOTAL_BITS +: TOTAL_BITS]};
      // Ascending scan: the last fitting coin is the largest one.
      if (i_coin_value[j*TOTAL_BITS +: TOTAL_BITS] <= balance_reg) begin
        ret_hit       = 1'b1;
        ret_onehot    = '0;
        ret_onehot[j] = 1'b1;
        ret_value     = i_coin_value[j*TOTAL_BITS +: TOTAL_BITS];
      end
    end
    // Descending scan: the last hit is the lowest selected available item.
    for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
      if (i_select_item[k] && o_available_item[k]) begin
        vend_hit       = 1'b1;
        vend_onehot    = '0;
        vend_onehot[k] = 1'b1;
        vend_price     = i_item_price[k*TOTAL_BITS +: TOTAL_BITS];
      end
    end
    coin_any  = |i_input_coin;
    total     = {1'b0, coin_sum} + {2'b00, balance_reg};
    overflow  = (total > MAX_BAL);
    coin_ok   = coin_any && !overflow && (state_reg != ST_RETURN);
    credit    = coin_ok ? coin_sum[TOTAL_BITS-1:0] : '0;
    // Availability guarantees price <= balance, so this never wraps.
    bal_after = balance_reg + credit - (vend_hit ? vend_price : '0);
  end

  // Next state, balance, timer and pulse outputs.
  always_comb begin
    state_next   = state_reg;
    balance_next = balance_reg;
    timer_next   = WAIT_INIT;
    item_next    = '0;
    ret_next     = '0;
    reject_next  = 1'b0;
    case (state_reg)
      ST_IDLE, ST_WAIT: begin
        reject_next  = coin_any && overflow;
        balance_next = bal_after;
        item_next    = vend_onehot;
        if (state_reg == ST_IDLE) begin
          if (coin_ok && bal_after != '0)
            state_next = ST_WAIT;
        end else begin
          if (bal_after == '0)
            state_next = ST_IDLE;
          else if (i_trigger_return)
            state_next = ST_RETURN;
          else if (!coin_ok && !vend_hit && timer_reg <= 16'd1)
            state_next = ST_RETURN;
        end
        if (state_next == ST_WAIT && state_reg == ST_WAIT && !coin_ok && !vend_hit)
          timer_next = timer_reg - 16'd1;
      end
      ST_RETURN: begin
        reject_next = coin_any;
        if (ret_hit) begin
          ret_next     = ret_onehot;
          balance_next = balance_reg - ret_value;
        end else begin
          // Residue below the smallest coin is forfeited.
          balance_next = '0;
        end
        if (balance_next == '0)
          state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      balance_reg <= '0;
      timer_reg   <= WAIT_INIT;
      item_reg    <= '0;
      ret_reg     <= '0;
      reject_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      balance_reg <= balance_next;
      timer_reg   <= timer_next;
      item_reg    <= item_next;
      ret_reg     <= ret_next;
      reject_reg  <= reject_next;
    end
  end

  assign o_output_item = item_reg;
  assign o_return_coin = ret_reg;
  assign o_coin_reject = reject_reg;
  assign o_balance     = balance_reg;
  assign o_busy        = (state_reg == ST_RETURN);

endmodule

// File: tb/tb_vending_fsm_param.sv
// Directed bench for vending_fsm_param: coins {100,500,1000},
// prices {400,500,1000,2000}, WAIT_CYCLES=10.
module tb_vending_fsm_param;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  i_input_coin = '0;
  logic [3:0]  i_select_item = '0;
  logic        i_trigger_return = 1'b0;
  logic [63:0] i_item_price = {16'd2000, 16'd1000, 16'd500, 16'd400};
  logic [47:0] i_coin_value = {16'd1000, 16'd500, 16'd100};
  logic [3:0]  i_restock_item = '0;
  logic [3:0]  o_available_item;
  logic [3:0]  o_output_item;
  logic [2:0]  o_return_coin;
  logic        o_coin_reject;
  logic [15:0] o_balance;
  logic        o_busy;

  int checks = 0;
  int errors = 0;

  vending_fsm_param #(
    .NUM_ITEMS(4), .NUM_COINS(3), .TOTAL_BITS(16), .WAIT_CYCLES(10)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_input_coin(i_input_coin),
    .i_select_item(i_select_item), .i_trigger_return(i_trigger_return),
    .i_item_price(i_item_price), .i_coin_value(i_coin_value),
    .i_restock_item(i_restock_item), .o_available_item(o_available_item),
    .o_output_item(o_output_item), .o_return_coin(o_return_coin),
    .o_coin_reject(o_coin_reject), .o_balance(o_balance), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic coin(input logic [2:0] m);
    i_input_coin = m;
    step();
    i_input_coin = '0;
  endtask

  task automatic sel(input logic [3:0] m);
    i_select_item = m;
    step();
    i_select_item = '0;
  endtask

  task automatic trig();
    i_trigger_return = 1'b1;
    step();
    i_trigger_return = 1'b0;
  endtask

  initial begin
    // Reset held two clocks with coins asserted
    i_input_coin = 3'b111;
    step();
    step();
    reset_n = 1'b1;
    i_input_coin = '0;
    check("rst_balance", o_balance, 0);
    check("rst_item", o_output_item, 0);
    check("rst_ret", o_return_coin, 0);
    check("rst_reject", o_coin_reject, 0);
    check("rst_busy", o_busy, 0);

    // Coins and vend
    coin(3'b010);
    check("bal_500", o_balance, 500);
    coin(3'b100);
    check("bal_1500", o_balance, 1500);
    check("avail_1500", o_available_item, 4'b0111);
    sel(4'b0010);
    check("vend_item1", o_output_item, 4'b0010);
    check("bal_1000", o_balance, 1000);
    step();
    check("vend_pulse_end", o_output_item, 4'b0000);
    sel(4'b0101);
    check("vend_lowest", o_output_item, 4'b0001);
    check("bal_600", o_balance, 600);
    sel(4'b1000);
    check("vend_unavail", o_output_item, 4'b0000);
    check("bal_still_600", o_balance, 600);

    // Greedy change return of 1600
    coin(3'b100);
    check("bal_1600", o_balance, 1600);
    trig();
    check("ret_busy0", o_busy, 1);
    check("ret_avail", o_available_item, 4'b0000);
    check("ret_pulse0", o_return_coin, 3'b000);
    step();
    check("ret_1000", o_return_coin, 3'b100);
    check("ret_bal600", o_balance, 600);
    check("ret_busy1", o_busy, 1);
    step();
    check("ret_500", o_return_coin, 3'b010);
    check("ret_busy2", o_busy, 1);
    step();
    check("ret_100", o_return_coin, 3'b001);
    check("ret_bal0", o_balance, 0);
    check("ret_busy3", o_busy, 0);
    step();
    check("ret_done", o_return_coin, 3'b000);

    // Trigger in IDLE ignored; two coins in one cycle
    trig();
    check("idle_trig", o_busy, 0);
    coin(3'b011);
    check("bal_multi", o_balance, 600);
    trig();
    step();
    check("multi_ret500", o_return_coin, 3'b010);
    step();
    check("multi_ret100", o_return_coin, 3'b001);
    check("multi_bal0", o_balance, 0);

    // Timeout after 10 idle cycles
    coin(3'b010);
    repeat (9) step();
    check("to_not_yet", o_busy, 0);
    step();
    check("to_busy", o_busy, 1);
    step();
    check("to_ret500", o_return_coin, 3'b010);
    check("to_bal0", o_balance, 0);

    // Coin at timer=3 reloads the timer
    coin(3'b010);
    repeat (7) step();
    coin(3'b001);
    check("reload_bal", o_balance, 600);
    repeat (9) step();
    check("reload_no_ret", o_busy, 0);
    step();
    check("reload_to", o_busy, 1);
    step();
    check("reload_ret500", o_return_coin, 3'b010);
    step();
    check("reload_ret100", o_return_coin, 3'b001);
    check("reload_bal0", o_balance, 0);

    // Overflow rejection and RETURN rejection
    repeat (65) coin(3'b100);
    check("bal_65000", o_balance, 65000);
    coin(3'b100);
    check("ovf_reject", o_coin_reject, 1);
    check("ovf_bal", o_balance, 65000);
    step();
    check("ovf_reject_end", o_coin_reject, 0);
    trig();
    coin(3'b001);
    check("rtn_reject", o_coin_reject, 1);
    check("rtn_ret1000", o_return_coin, 3'b100);
    check("rtn_bal", o_balance, 64000);
    for (int n = 0; n < 200 && o_busy; n++) step();
    check("rtn_finished", o_busy, 0);
    check("rtn_bal0", o_balance, 0);

`ifdef VM_ITEM_STOCK_EN
    // Stock exhaustion and restock
    repeat (7) coin(3'b100);
    check("stk_bal7000", o_balance, 7000);
    repeat (15) sel(4'b0001);
    check("stk_bal1000", o_balance, 1000);
    check("stk_avail", o_available_item, 4'b0110);
    sel(4'b0001);
    check("stk_no_vend", o_output_item, 4'b0000);
    i_restock_item = 4'b0001;
    step();
    i_restock_item = '0;
    check("stk_restock", o_available_item, 4'b0111);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
